frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Per-frame update scheduler for the game datapath.
- Sits between the game-state controller (reset/enable) and three datapath units: hero physics, pipe scroller and collision checker.
- Generates the frame tick and runs the units in a fixed order over start/done handshakes.
- Latches jump presses between frames, emits score increments and a sticky dead flag back to the controller.

Parameters:
- TICK_DIV, 1666667, clk cycles per frame (60 Hz at 100 MHz); must be >= 8.
- WDOG, 4095, maximum cycles to wait for any done before declaring a fault.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; driven by the game-state controller.
- enable  in  1  high = playing; low = paused or dead.
- jump  in  1  one-cycle jump pulse, already debounced.
- hero_start  out  1  one-cycle start pulse to hero physics.
- hero_jump  out  1  jump request; valid while hero_start is high.
- hero_done  in  1  one-cycle completion from hero physics.
- pipe_start  out  1  one-cycle start pulse to pipe scroller.
- pipe_done  in  1  completion from pipe scroller.
- pipe_passed  in  1  hero cleared a pipe; sampled with pipe_done.
- coll_start  out  1  one-cycle start pulse to collision checker.
- coll_done  in  1  completion from collision checker.
- hit  in  1  collision result; sampled with coll_done.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- score_inc  out  1  one-cycle score increment.
- dead  out  1  sticky; hero hit.
- fault  out  1  sticky; watchdog expired.
- overrun  out  1  sticky; tick arrived while a frame was still in progress.
- busy  out  1  FSM not in IDLE.
- frame_cnt  out  FCNT_W  completed frames; wraps at 2^FCNT_W.

Behaviour:
- Reset (synchronous, any state or cycle):
  - FSM goes to IDLE.
  - Tick counter, watchdog, jump latch, pass latch and frame_cnt clear to 0.
  - All outputs are 0 in the cycle after reset is sampled high.
  - Reset wins over every other input in the same cycle.
- Tick counter:
  - Increments only while enable=1 and dead=0 and fault=0; it holds its value otherwise (pause resumes the count mid-frame).
  - At TICK_DIV-1 it wraps to 0 and frame_tick pulses on the following cycle.
- Jump latch:
  - Set by jump while enable=1.
  - Cleared in the cycle hero_start is asserted.
  - If jump and hero_start coincide, the latch stays set for the next frame; that press is not lost.
- FSM states: IDLE, HERO, PIPE, COLL, COMMIT.
  - IDLE: on frame_tick, assert hero_start and hero_jump=latch, then go to HERO.
  - HERO: wait for hero_done. Then assert pipe_start and go to PIPE.
  - PIPE: wait for pipe_done. Capture pipe_passed into the pass latch, assert coll_start and go to COLL.
  - COLL: wait for coll_done. Capture hit and go to COMMIT.
  - COMMIT (one cycle):
    - frame_cnt +1.
    - score_inc = pass latch AND NOT hit.
    - If hit, set dead.
    - Go to IDLE.
- Start-to-done latency: each start pulse occurs in the cycle the FSM enters the new state. A done in that same cycle is ignored; done is accepted from the next cycle on.
- Spurious done: a done received outside its matching state is ignored.
- Watchdog:
  - Reloads to 0 on every state entry and counts while in HERO, PIPE or COLL.
  - Reaching WDOG sets fault, goes to IDLE, and produces no COMMIT.
- Overrun: a frame_tick while busy=1 sets overrun. That tick is dropped, not queued.
- enable falls mid-frame: the in-progress frame runs to COMMIT. No new tick is generated until enable returns.
- dead or fault set: no further frame_tick or start pulses occur until reset.
- busy = (state != IDLE).

Test Plan:
- TICK_DIV=8, enable=1, done pulses returned 2 cycles after each start, pipe_passed=1, hit=0 -> frame_tick every 8 cycles; hero_start, pipe_start, coll_start in order; score_inc once per frame; frame_cnt=3 after 3 frames; overrun=0.
- jump pulsed 3 cycles before a tick -> hero_jump=1 with that hero_start, hero_jump=0 on the next frame. Second case: jump coincident with hero_start -> hero_jump=1 on the following frame.
- coll_done with hit=1 and pipe_passed=1 -> score_inc=0, dead=1 after COMMIT; no frame_tick for 50 further cycles; frame_cnt increments by 1.
- enable dropped at tick count 5 for 20 cycles, then raised -> next frame_tick 3 cycles after enable rises. Second case: enable dropped during PIPE -> frame still completes, frame_cnt +1.
- hero_done withheld, WDOG=15 -> fault=1 exactly 15 cycles after entering HERO; FSM returns to IDLE; no pipe_start.
- Done latency 10 with TICK_DIV=8 -> overrun=1 and that tick dropped. Second case: reset asserted in COLL -> next cycle all outputs 0, frame_cnt=0; a subsequent coll_done is ignored.

Source files
------------

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: derives the frame tick, then runs hero physics, pipe scroller
// and collision checker in order over start/done handshakes, reporting score/dead/fault.
module frame_sequencer #(
    parameter int unsigned TICK_DIV = 1666667,
    parameter int unsigned WDOG     = 4095,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              jump,
    output logic              hero_start,
    output logic              hero_jump,
    input  logic              hero_done,
    output logic              pipe_start,
    input  logic              pipe_done,
    input  logic              pipe_passed,
    output logic              coll_start,
    input  logic              coll_done,
    input  logic              hit,
    output logic              frame_tick,
    output logic              score_inc,
    output logic              dead,
    output logic              fault,
    output logic              overrun,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WW = $clog2(WDOG + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HERO   = 3'd1,
        S_PIPE   = 3'd2,
        S_COLL   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               jump_q, jump_d;
    logic               pass_q, pass_d;
    logic               frame_tick_q, frame_tick_d;
    logic               hero_start_q, hero_start_d;
    logic               hero_jump_q, hero_jump_d;
    logic               pipe_start_q, pipe_start_d;
    logic               coll_start_q, coll_start_d;
    logic               score_inc_q, score_inc_d;
    logic               dead_q, dead_d;
    logic               fault_q, fault_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               run;
    logic               tick_wrap;
    logic               launch;

    // Next-state logic: tick divider, handshake FSM, watchdog and sticky flags.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        wdog_d       = WW'(0);
        frame_cnt_d  = frame_cnt_q;
        jump_d       = jump_q;
        pass_d       = pass_q;
        frame_tick_d = 1'b0;
        hero_start_d = 1'b0;
        hero_jump_d  = 1'b0;
        pipe_start_d = 1'b0;
        coll_start_d = 1'b0;
        score_inc_d  = 1'b0;
        dead_d       = dead_q;
        fault_d      = fault_q;
        overrun_d    = overrun_q;
        launch       = 1'b0;

        run       = enable && !dead_q && !fault_q;
        tick_wrap = run && (tick_cnt_q == TICK_LAST);
        if (run) begin
            if (tick_wrap) begin
                tick_cnt_d = TW'(0);
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        // A tick that finds the FSM mid-frame is recorded and dropped.
        if (frame_tick_q && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        // The start pulse marks the entry cycle, so a done in that cycle is ignored.
        case (state_q)
            S_IDLE: begin
                if (frame_tick_q && !dead_q && !fault_q) begin
                    state_d      = S_HERO;
                    hero_start_d = 1'b1;
                    hero_jump_d  = jump_q;
                    launch       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HERO: begin
                if (hero_done && !hero_start_q) begin
                    state_d      = S_PIPE;
                    pipe_start_d = 1'b1;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_PIPE: begin
                if (pipe_done && !pipe_start_q) begin
                    state_d      = S_COLL;
                    pass_d       = pipe_passed;
                    coll_start_d = 1'b1;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_COLL: begin
                if (coll_done && !coll_start_q) begin
                    state_d     = S_COMMIT;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    score_inc_d = pass_q && !hit;
                    dead_d      = dead_q || hit;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A press coinciding with the launch survives into the next frame.
        if (enable && jump) begin
            jump_d = 1'b1;
        end else if (launch) begin
            jump_d = 1'b0;
        end else begin
            jump_d = jump_q;
        end

        frame_tick_d = tick_wrap && !dead_d && !fault_d;
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= TW'(0);
            wdog_q       <= WW'(0);
            frame_cnt_q  <= FCNT_W'(0);
            jump_q       <= 1'b0;
            pass_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            hero_start_q <= 1'b0;
            hero_jump_q  <= 1'b0;
            pipe_start_q <= 1'b0;
            coll_start_q <= 1'b0;
            score_inc_q  <= 1'b0;
            dead_q       <= 1'b0;
            fault_q      <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            wdog_q       <= wdog_d;
            frame_cnt_q  <= frame_cnt_d;
            jump_q       <= jump_d;
            pass_q       <= pass_d;
            frame_tick_q <= frame_tick_d;
            hero_start_q <= hero_start_d;
            hero_jump_q  <= hero_jump_d;
            pipe_start_q <= pipe_start_d;
            coll_start_q <= coll_start_d;
            score_inc_q  <= score_inc_d;
            dead_q       <= dead_d;
            fault_q      <= fault_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign hero_start = hero_start_q;
    assign hero_jump  = hero_jump_q;
    assign pipe_start = pipe_start_q;
    assign coll_start = coll_start_q;
    assign frame_tick = frame_tick_q;
    assign score_inc  = score_inc_q;
    assign dead       = dead_q;
    assign fault      = fault_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected output events are queued with their
// cycle stamp; a negedge monitor pops and compares each event the DUT presents.
module tb_frame_sequencer;

    localparam int K_TICK  = 1;
    localparam int K_HERO  = 2;
    localparam int K_PIPE  = 3;
    localparam int K_COLL  = 4;
    localparam int K_SCORE = 5;
    localparam int K_FAULT = 6;
    localparam int K_DEAD  = 7;
    localparam int K_OVR   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        jump = 1'b0;
    logic        hero_start, hero_jump, pipe_start, coll_start;
    logic        hero_done, pipe_done, pipe_passed, coll_done, hit;
    logic        frame_tick, score_inc, dead, fault, overrun, busy;
    logic [15:0] frame_cnt;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   hero_lat = 2;
    int   pipe_lat = 2;
    int   coll_lat = 2;
    logic pipe_pass_v = 1'b1;
    logic coll_hit_v = 1'b0;
    logic fault_p = 1'b0;
    logic dead_p = 1'b0;
    logic ovr_p = 1'b0;

    frame_sequencer #(.TICK_DIV(8), .WDOG(15), .FCNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .jump(jump),
        .hero_start(hero_start), .hero_jump(hero_jump), .hero_done(hero_done),
        .pipe_start(pipe_start), .pipe_done(pipe_done), .pipe_passed(pipe_passed),
        .coll_start(coll_start), .coll_done(coll_done), .hit(hit),
        .frame_tick(frame_tick), .score_inc(score_inc), .dead(dead), .fault(fault),
        .overrun(overrun), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int t, input int jmp, input int fc);
        push(K_TICK, t, 0);
        push(K_HERO, t + 1, jmp);
        push(K_PIPE, t + 3, 0);
        push(K_COLL, t + 5, 0);
        push(K_SCORE, t + 7, fc);
    endtask

    task automatic mon_ev(input int k, input int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d cycle=%0d data=%0d, expected none", k, cyc, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d) begin
                failures++;
                $display("FAIL event: got kind=%0d cycle=%0d data=%0d expected kind=%0d cycle=%0d data=%0d",
                         k, cyc, d, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every output event the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (frame_tick === 1'b1) mon_ev(K_TICK, 0);
        if (hero_start === 1'b1) mon_ev(K_HERO, int'(hero_jump));
        if (pipe_start === 1'b1) mon_ev(K_PIPE, 0);
        if (coll_start === 1'b1) mon_ev(K_COLL, 0);
        if (score_inc === 1'b1) mon_ev(K_SCORE, int'(frame_cnt));
        if (fault === 1'b1 && fault_p !== 1'b1) mon_ev(K_FAULT, 0);
        if (dead === 1'b1 && dead_p !== 1'b1) mon_ev(K_DEAD, int'(frame_cnt));
        if (overrun === 1'b1 && ovr_p !== 1'b1) mon_ev(K_OVR, 0);
        fault_p = fault;
        dead_p  = dead;
        ovr_p   = overrun;
    end

    // Unit responders: done is sampled on the lat-th clock edge after the start edge.
    initial begin
        hero_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hero_start === 1'b1 && hero_lat > 0) begin
                repeat (hero_lat - 1) @(posedge clk);
                #1 hero_done = 1'b1;
                @(posedge clk);
                #1 hero_done = 1'b0;
            end
        end
    end

    initial begin
        pipe_done   = 1'b0;
        pipe_passed = 1'b0;
        forever begin
            @(negedge clk);
            if (pipe_start === 1'b1 && pipe_lat > 0) begin
                repeat (pipe_lat - 1) @(posedge clk);
                #1 pipe_done = 1'b1;
                pipe_passed = pipe_pass_v;
                @(posedge clk);
                #1 pipe_done = 1'b0;
                pipe_passed = 1'b0;
            end
        end
    end

    initial begin
        coll_done = 1'b0;
        hit       = 1'b0;
        forever begin
            @(negedge clk);
            if (coll_start === 1'b1 && coll_lat > 0) begin
                repeat (coll_lat - 1) @(posedge clk);
                #1 coll_done = 1'b1;
                hit = coll_hit_v;
                @(posedge clk);
                #1 coll_done = 1'b0;
                hit = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        jump   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_flags"}, {26'd0, dead, fault, overrun, frame_tick, score_inc, 1'b0}, 32'd0);
        check({tag, "_starts"}, {28'd0, hero_start, hero_jump, pipe_start, coll_start}, 32'd0);
    endtask

    initial begin
        int c0;
        int c1;
        int c2;
        int t;

        // Reset state, steady frames, jump latch, then a fatal hit.
        do_reset();
        c0 = cyc;
        check_all_zero("reset");
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            push_frame(c0 + 8 * k, (k == 4 || k == 6) ? 1 : 0, k);
        end
        push(K_TICK, c0 + 56, 0);
        push(K_HERO, c0 + 57, 0);
        push(K_PIPE, c0 + 59, 0);
        push(K_COLL, c0 + 61, 0);
        push(K_DEAD, c0 + 63, 7);
        wait_cyc(c0 + 29);
        jump = 1'b1;
        step();
        jump = 1'b0;
        wait_cyc(c0 + 32);
        check("frames3_cnt", {16'd0, frame_cnt}, 32'd3);
        check("frames3_overrun", {31'd0, overrun}, 32'd0);
        wait_cyc(c0 + 41);
        check("jump_coincident_start", {31'd0, hero_start}, 32'd1);
        jump = 1'b1;
        step();
        jump = 1'b0;
        wait_cyc(c0 + 57);
        coll_hit_v = 1'b1;
        wait_cyc(c0 + 113);
        check("hit_dead", {31'd0, dead}, 32'd1);
        check("hit_frame_cnt", {16'd0, frame_cnt}, 32'd7);
        check("hit_busy", {31'd0, busy}, 32'd0);
        coll_hit_v = 1'b0;

        // Pause at tick count 5, then enable dropped while in PIPE.
        do_reset();
        c1 = cyc;
        enable = 1'b1;
        push_frame(c1 + 8, 0, 1);
        push_frame(c1 + 36, 0, 2);
        wait_cyc(c1 + 13);
        enable = 1'b0;
        wait_cyc(c1 + 33);
        enable = 1'b1;
        wait_cyc(c1 + 39);
        enable = 1'b0;
        wait_cyc(c1 + 70);
        check("pause_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        check("pause_busy", {31'd0, busy}, 32'd0);

        // Watchdog: hero_done withheld.
        do_reset();
        c2 = cyc;
        enable = 1'b1;
        hero_lat = 0;
        push(K_TICK, c2 + 8, 0);
        push(K_HERO, c2 + 9, 0);
        push(K_FAULT, c2 + 24, 0);
        wait_cyc(c2 + 9);
        enable = 1'b0;
        wait_cyc(c2 + 40);
        check("wdog_fault", {31'd0, fault}, 32'd1);
        check("wdog_busy", {31'd0, busy}, 32'd0);
        check("wdog_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        hero_lat = 2;

        // Overrun from a slow hero, then reset while in COLL.
        do_reset();
        t = cyc + 8;
        enable = 1'b1;
        hero_lat = 10;
        push(K_TICK, t, 0);
        push(K_HERO, t + 1, 0);
        push(K_TICK, t + 8, 0);
        push(K_OVR, t + 9, 0);
        push(K_PIPE, t + 11, 0);
        push(K_COLL, t + 13, 0);
        push(K_SCORE, t + 15, 1);
        push_frame(t + 16, 0, 2);
        push(K_TICK, t + 24, 0);
        push(K_HERO, t + 25, 0);
        push(K_PIPE, t + 27, 0);
        push(K_COLL, t + 29, 0);
        wait_cyc(t + 12);
        hero_lat = 2;
        wait_cyc(t + 20);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        wait_cyc(t + 24);
        coll_lat = 4;
        wait_cyc(t + 30);
        check("coll_busy_before_reset", {31'd0, busy}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        reset = 1'b0;
        check_all_zero("reset_in_coll");
        wait_cyc(t + 45);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        coll_lat = 2;

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
